// File: rtl/memc_pkg.sv
// rtl/memc_pkg.sv - shared types and helpers for the QSPI memory sequencer
package memc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE,
    ST_GAP
  } seq_state_t;

  localparam logic [1:0] MT_NONE = 2'b00;
  localparam logic [1:0] MT_BYTE = 2'b01;
  localparam logic [1:0] MT_HALF = 2'b10;
  localparam logic [1:0] MT_WORD = 2'b11;

  function automatic logic [3:0] nibbles(input logic [1:0] mt);
    logic [3:0] n;
    case (mt)
      MT_BYTE: n = 4'd2;
      MT_HALF: n = 4'd4;
      MT_WORD: n = 4'd8;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  // Bit-reversed-ish interleave the controller uses to place each nibble.
  function automatic logic [2:0] pos_code(input logic [2:0] k);
    return {k[0], k[2:1]};
  endfunction

endpackage

// File: rtl/qspi_io_shifter.sv
// rtl/qspi_io_shifter.sv - per-cycle IO drive mux and read-capture register
// Command phase width selected by QSPI_CMD_QUAD_EN (defined: 2 quad cycles, undefined: 8 serial cycles).
module qspi_io_shifter
  import memc_pkg::*;
(
  input  logic       delayClk,
  input  logic       rst,
  input  seq_state_t state,
  input  logic [3:0] phase,
  input  logic [7:0] opcode,
  input  logic [23:0] addr,
  input  logic       is_write,
  input  logic [3:0] wr_nibble,
  input  logic [3:0] io_in,
  input  logic       capture,
  output logic [3:0] io_out,
  output logic [3:0] io_oe,
  output logic [3:0] rd_nibble,
  output logic [2:0] rd_pos
);

  logic [3:0]  rd_nibble_q, rd_nibble_d;
  logic [2:0]  rd_pos_q, rd_pos_d;
  logic [23:0] addr_sh;
  logic [7:0]  op_sh;

  always_comb begin
    io_out  = 4'h0;
    io_oe   = 4'h0;
    addr_sh = addr << {phase, 2'b00};
    op_sh   = opcode << phase[2:0];
    case (state)
      ST_CMD: begin
`ifdef QSPI_CMD_QUAD_EN
        io_out = phase[0] ? opcode[3:0] : opcode[7:4];
        io_oe  = 4'hF;
`else
        io_out = {3'b000, op_sh[7]};
        io_oe  = 4'b0001;
`endif
      end
      ST_ADDR: begin
        io_out = addr_sh[23:20];
        io_oe  = 4'hF;
      end
      ST_DATA: begin
        if (is_write) begin
          io_out = wr_nibble;
          io_oe  = 4'hF;
        end
      end
      default: begin
        io_out = 4'h0;
        io_oe  = 4'h0;
      end
    endcase
  end

  always_comb begin
    rd_nibble_d = rd_nibble_q;
    rd_pos_d    = rd_pos_q;
    if (capture) begin
      rd_nibble_d = io_in;
      rd_pos_d    = pos_code(phase[2:0]);
    end
  end

  always_ff @(posedge delayClk or posedge rst) begin
    if (rst) begin
      rd_nibble_q <= 4'h0;
      rd_pos_q    <= 3'b000;
    end else begin
      rd_nibble_q <= rd_nibble_d;
      rd_pos_q    <= rd_pos_d;
    end
  end

  assign rd_nibble = rd_nibble_q;
  assign rd_pos    = rd_pos_q;

endmodule

// File: rtl/qspi_mem_sequencer.sv
// rtl/qspi_mem_sequencer.sv - one QSPI transaction per controller request
// Command phase width selected by QSPI_CMD_QUAD_EN (defined: 2 quad cycles, undefined: 8 serial cycles).
module qspi_mem_sequencer
  import memc_pkg::*;
#(
  parameter logic [7:0] CMD_READ     = 8'hEB,
  parameter logic [7:0] CMD_WRITE    = 8'h38,
  parameter int         DUMMY_CYCLES = 6,
  parameter int         CS_HIGH_MIN  = 2
) (
  input  logic        delayClk,
  input  logic        rst,
  input  logic        req,
  input  logic        reqWrite,
  input  logic [23:0] spiAddr,
  input  logic [1:0]  memType,
  input  logic [3:0]  wrNibble,
  output logic [3:0]  memDataIn,
  output logic [2:0]  dataPosIn,
  output logic        memClk,
  output logic        memReady,
  output logic        busy,
  output logic        spiCs_n,
  output logic        spiSclk,
  output logic [3:0]  spiIoOut,
  output logic [3:0]  spiIoOe,
  input  logic [3:0]  spiIoIn
);

`ifdef QSPI_CMD_QUAD_EN
  localparam logic [3:0] CMD_LAST = 4'd1;
`else
  localparam logic [3:0] CMD_LAST = 4'd7;
`endif
  localparam logic [3:0] ADDR_LAST  = 4'd5;
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);
  // DONE already supplies the first CS-high cycle; GAP covers the rest.
  localparam logic [3:0] GAP_LAST   = 4'((CS_HIGH_MIN > 1) ? (CS_HIGH_MIN - 2) : 0);

  seq_state_t  state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic [23:0] addr_q, addr_d;
  logic [1:0]  type_q, type_d;
  logic        write_q, write_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_en_q, sclk_en_d;
  logic        busy_q, busy_d;
  logic        mem_clk_q, mem_clk_d;
  logic        mem_ready_q, mem_ready_d;
  logic [3:0]  data_last;
  logic        active;
  logic        capture;
  logic [7:0]  opcode;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 4'd1;
    addr_d    = addr_q;
    type_d    = type_q;
    write_d   = write_q;
    data_last = nibbles(type_q) - 4'd1;
    case (state_q)
      ST_IDLE: begin
        phase_d = 4'd0;
        if (req && (memType != MT_NONE)) begin
          state_d = ST_CMD;
          addr_d  = spiAddr;
          type_d  = memType;
          write_d = reqWrite;
        end
      end
      ST_CMD: begin
        if (phase_q == CMD_LAST) begin
          state_d = ST_ADDR;
          phase_d = 4'd0;
        end
      end
      ST_ADDR: begin
        if (phase_q == ADDR_LAST) begin
          state_d = write_q ? ST_DATA : ST_DUMMY;
          phase_d = 4'd0;
        end
      end
      ST_DUMMY: begin
        if (phase_q == DUMMY_LAST) begin
          state_d = ST_DATA;
          phase_d = 4'd0;
        end
      end
      ST_DATA: begin
        if (phase_q == data_last) begin
          state_d = ST_DONE;
          phase_d = 4'd0;
        end
      end
      ST_DONE: begin
        state_d = (CS_HIGH_MIN > 1) ? ST_GAP : ST_IDLE;
        phase_d = 4'd0;
      end
      ST_GAP: begin
        if (phase_q == GAP_LAST) begin
          state_d = ST_IDLE;
          phase_d = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 4'd0;
      end
    endcase

    // Strobes and bus controls are registered from the next state so they launch on the rising edge.
    active      = state_d inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
    cs_n_d      = ~active;
    sclk_en_d   = active;
    busy_d      = (state_d != ST_IDLE);
    mem_ready_d = (state_d == ST_DONE);
    // Write strobes every DATA cycle; read strobes the cycle after each capture.
    mem_clk_d   = write_q ? (state_d == ST_DATA) : (state_q == ST_DATA);
  end

  always_ff @(posedge delayClk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= 4'd0;
      addr_q      <= 24'h0;
      type_q      <= MT_NONE;
      write_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_clk_q   <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      type_q      <= type_d;
      write_q     <= write_d;
      cs_n_q      <= cs_n_d;
      sclk_en_q   <= sclk_en_d;
      busy_q      <= busy_d;
      mem_clk_q   <= mem_clk_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  assign capture = (state_q == ST_DATA) && !write_q;
  assign opcode  = write_q ? CMD_WRITE : CMD_READ;

  qspi_io_shifter u_io (
    .delayClk  (delayClk),
    .rst       (rst),
    .state     (state_q),
    .phase     (phase_q),
    .opcode    (opcode),
    .addr      (addr_q),
    .is_write  (write_q),
    .wr_nibble (wrNibble),
    .io_in     (spiIoIn),
    .capture   (capture),
    .io_out    (spiIoOut),
    .io_oe     (spiIoOe),
    .rd_nibble (memDataIn),
    .rd_pos    (dataPosIn)
  );

  // Enable toggles only while delayClk is high, so the gated clock cannot glitch.
  assign spiSclk  = sclk_en_q & ~delayClk;
  assign spiCs_n  = cs_n_q;
  assign busy     = busy_q;
  assign memClk   = mem_clk_q;
  assign memReady = mem_ready_q;

endmodule
